// File: rtl/musicbox_pkg.sv
// Shared definitions for the musicbox tone path.
//   - seq_state_t : playback FSM states
//   - rom_data field positions for the song ROM word
//   - CLK_HZ      : system clock frequency, used to derive tick rates
package musicbox_pkg;

    localparam int CLK_HZ = 100_000_000;

    // Song ROM word layout: {end, duration[6:0], rest, note[6:0]}
    localparam int END_BIT  = 15;
    localparam int DUR_MSB  = 14;
    localparam int DUR_LSB  = 8;
    localparam int REST_BIT = 7;
    localparam int NOTE_MSB = 6;
    localparam int DUR_W    = DUR_MSB - DUR_LSB + 1;
    localparam int NOTE_W   = NOTE_MSB + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/beat_tick.sv
// Duration-tick prescaler. Counts 0..TICK_DIV-1 while enabled and wraps;
// holds its count while disabled.
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   clear  in  force the count back to 0 (wins over enable)
//   enable in  advance the count this cycle
//   tick   out one-cycle strobe: enabled and count at TICK_DIV-1
module beat_tick #(
    parameter int TICK_DIV = 6_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song playback controller: walks the song ROM entry by entry, holds each
// note for its encoded duration, and drives the tone generator.
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   pp         in  play (1) / pause (0) level
//   next       in  next-song button level, edge-detected here
//   rom_addr   out {song_idx, step}, sampled by the registered ROM
//   rom_data   in  ROM word, valid one cycle after rom_addr
//   note       out current fullnote code
//   note_valid out tone enable
//   song_idx   out current song
//   step       out current entry within the song
//   tick       out one-cycle duration-tick strobe
//
// state | meaning
// FETCH | rom_addr presented; ROM samples it at the closing edge (waits while paused)
// LOAD  | rom_data valid; latch entry or handle end-of-song loop
// HOLD  | note sounding; count down duration ticks (frozen while paused)
module song_sequencer
    import musicbox_pkg::*;
#(
    parameter int TICK_DIV = CLK_HZ / 16,
    parameter int SONG_W   = 2,
    parameter int STEP_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pp,
    input  logic                     next,
    output logic [SONG_W+STEP_W-1:0] rom_addr,
    input  logic [15:0]              rom_data,
    output logic [NOTE_W-1:0]        note,
    output logic                     note_valid,
    output logic [SONG_W-1:0]        song_idx,
    output logic [STEP_W-1:0]        step,
    output logic                     tick
);

    seq_state_t        state_q;
    logic [SONG_W-1:0] song_q;
    logic [STEP_W-1:0] step_q;
    logic [NOTE_W-1:0] note_q;
    logic              rest_q;
    logic [DUR_W-1:0]  dur_q;
    logic              next_q;

    logic             next_edge;
    logic             presc_clear;
    logic             presc_en;
    logic [DUR_W-1:0] dur_raw;

    assign next_edge   = next && !next_q;
    assign presc_en    = (state_q == HOLD) && pp;
    assign presc_clear = (state_q == LOAD) || next_edge;
    assign dur_raw     = rom_data[DUR_MSB:DUR_LSB];

    beat_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_beat_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (presc_clear),
        .enable (presc_en),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            song_q  <= '0;
            step_q  <= '0;
            note_q  <= '0;
            rest_q  <= 1'b1;
            dur_q   <= '0;
            next_q  <= 1'b0;
        end else begin
            next_q <= next;
            if (next_edge) begin
                // Song change pre-empts whatever the FSM was doing, paused or not.
                song_q  <= song_q + 1'b1;
                step_q  <= '0;
                state_q <= FETCH;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (pp) begin
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (rom_data[END_BIT]) begin
                            step_q  <= '0;
                            state_q <= FETCH;
                        end else begin
                            note_q  <= rom_data[NOTE_MSB:0];
                            rest_q  <= rom_data[REST_BIT];
                            // A zero duration still plays for one tick.
                            dur_q   <= (dur_raw == '0) ? DUR_W'(1) : dur_raw;
                            state_q <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            dur_q <= dur_q - 1'b1;
                            if (dur_q == DUR_W'(1)) begin
                                step_q  <= step_q + 1'b1;
                                state_q <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state_q <= FETCH;
                    end
                endcase
            end
        end
    end

    assign rom_addr   = {song_q, step_q};
    assign note       = note_q;
    assign note_valid = (state_q == HOLD) && pp && !rest_q;
    assign song_idx   = song_q;
    assign step       = step_q;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pp;
    logic        next;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [6:0]  note;
    logic        note_valid;
    logic [1:0]  song_idx;
    logic [5:0]  step;
    logic        tick;

    logic [15:0] rom [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural registered ROM, one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    song_sequencer #(
        .TICK_DIV (4),
        .SONG_W   (2),
        .STEP_W   (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pp         (pp),
        .next       (next),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .note_valid (note_valid),
        .song_idx   (song_idx),
        .step       (step),
        .tick       (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next sample point: 1 ns after the falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Count consecutive note_valid-high cycles from now, and ticks within them.
    task automatic measure_high(output int run, output int ticks);
        run = 0;
        ticks = 0;
        while (note_valid === 1'b1 && run < 200) begin
            run++;
            if (tick === 1'b1) ticks++;
            cyc(1);
        end
    endtask

    initial begin
        int run;
        int ticks;
        int cnt;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]   = 16'h0305;   // note 5, dur 3
        rom[1]   = 16'h0109;   // note 9, dur 1
        rom[2]   = 16'h8000;   // end
        rom[64]  = 16'h0287;   // rest, dur 2
        rom[65]  = 16'h000C;   // note 12, dur 0
        rom[66]  = 16'h8000;
        for (int i = 0; i < 64; i++) rom[128 + i] = 16'h0100 | 16'(i + 1);
        rom[192] = 16'h8000;   // empty song

        rst  = 1'b1;
        pp   = 1'b0;
        next = 1'b0;
        cyc(2);
        check("reset_note", 32'(note), 32'h0);
        check("reset_nv", 32'(note_valid), 32'h0);
        check("reset_song", 32'(song_idx), 32'h0);
        check("reset_step", 32'(step), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_addr", 32'(rom_addr), 32'h0);

        // Basic playback: cycle 0 is FETCH
        rst = 1'b0;
        pp  = 1'b1;
        cyc(1);                                   // cycle 1, LOAD
        check("load_nv_low", 32'(note_valid), 32'h0);
        cyc(1);                                   // cycle 2, HOLD
        check("note5", 32'(note), 32'd5);
        check("note5_nv", 32'(note_valid), 32'h1);
        measure_high(run, ticks);                 // ends at cycle 14
        check("note5_len", 32'(run), 32'd12);
        check("note5_ticks", 32'(ticks), 32'd3);
        check("note_hold_fetch", 32'(note), 32'd5);
        check("step1", 32'(step), 32'd1);
        cyc(1);
        check("gap_nv", 32'(note_valid), 32'h0);
        cyc(1);                                   // cycle 16
        check("note9", 32'(note), 32'd9);
        measure_high(run, ticks);                 // ends at cycle 20
        check("note9_len", 32'(run), 32'd4);
        check("note9_ticks", 32'(ticks), 32'd1);
        cyc(4);                                   // cycle 24, looped
        check("loop_note", 32'(note), 32'd5);
        check("loop_step", 32'(step), 32'd0);
        check("loop_nv", 32'(note_valid), 32'h1);

        // Pause across cycles 26..32 during third HOLD cycle
        cyc(2);
        pp = 1'b0;
        #1;
        check("pause_mute", 32'(note_valid), 32'h0);
        cnt = (tick === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (tick !== 1'b0) cnt++;
        end
        check("pause_ticks", 32'(cnt), 32'd0);
        check("pause_step", 32'(step), 32'd0);
        cyc(1);                                   // cycle 33
        pp = 1'b1;
        #1;
        measure_high(run, ticks);                 // ends at cycle 43
        check("pause_rest_len", 32'(run), 32'd10);
        check("pause_ticks_after", 32'(ticks), 32'd3);
        check("pause_end_step", 32'(step), 32'd1);

        // Next-song edge during song 0 step 1 HOLD, held 20 cycles
        cyc(3);                                   // cycle 46
        check("pre_next_nv", 32'(note_valid), 32'h1);
        next = 1'b1;
        cyc(1);                                   // cycle 47
        check("next_song", 32'(song_idx), 32'd1);
        check("next_step", 32'(step), 32'd0);
        check("next_addr", 32'(rom_addr), 32'h40);
        check("next_nv", 32'(note_valid), 32'h0);

        // Rest entry and zero-duration entry of song 1
        cyc(2);                                   // cycle 49
        check("rest_note", 32'(note), 32'd7);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (note_valid !== 1'b0) cnt++;
            if (i == 7) check("rest_last_step", 32'(step), 32'd0);
            cyc(1);
        end
        check("rest_silent", 32'(cnt), 32'd0);
        check("rest_len_step", 32'(step), 32'd1);
        cyc(2);                                   // cycle 59
        check("dur0_note", 32'(note), 32'd12);
        measure_high(run, ticks);
        check("dur0_len", 32'(run), 32'd4);
        check("dur0_step", 32'(step), 32'd2);
        cyc(3);                                   // cycle 66
        check("held_next_once", 32'(song_idx), 32'd1);
        next = 1'b0;

        // Song 2 has no end marker: step wraps
        cyc(1);                                   // cycle 67
        next = 1'b1;
        cyc(1);                                   // cycle 68
        next = 1'b0;
        check("song2", 32'(song_idx), 32'd2);
        cyc(378);                                 // cycle 446
        check("step63", 32'(step), 32'd63);
        cyc(2);
        check("step63_note", 32'(note), 32'd64);
        cyc(4);                                   // cycle 452
        check("step_wrap", 32'(step), 32'd0);
        check("step_wrap_song", 32'(song_idx), 32'd2);

        // Empty song 3
        next = 1'b1;
        cyc(1);
        next = 1'b0;
        check("song3", 32'(song_idx), 32'd3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (note_valid !== 1'b0 || step !== 6'd0) cnt++;
            cyc(1);
        end
        check("empty_silent", 32'(cnt), 32'd0);
        next = 1'b1;
        cyc(1);                                   // wrap to song 0
        next = 1'b0;
        check("song_wrap", 32'(song_idx), 32'd0);
        check("song_wrap_addr", 32'(rom_addr), 32'h00);

        // Reset during HOLD of song 0 step 1
        cyc(16);
        check("prerst_note", 32'(note), 32'd9);
        check("prerst_step", 32'(step), 32'd1);
        rst = 1'b1;
        cyc(1);
        check("rst_note", 32'(note), 32'h0);
        check("rst_nv", 32'(note_valid), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        check("rst_song", 32'(song_idx), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        rst = 1'b0;
        cyc(1);
        check("rst_load_nv", 32'(note_valid), 32'h0);
        cyc(1);
        check("rst_hold_nv", 32'(note_valid), 32'h1);
        check("rst_hold_note", 32'(note), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
